// File: rtl/vu_meter_ballistics_if.sv
// Audio-side and meter-side signal bundle for vu_meter_ballistics.
// The master drives samples and strobes; the slave (the meter driver) returns PWM, levels and peaks.
interface vu_meter_ballistics_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned PWM_W    = 7
);
  logic                       audio_clk_enable;
  logic                       audio_enable;
  logic [NUM_CH*SAMPLE_W-1:0] audio_sample;
  logic [NUM_CH-1:0]          vu_pwm;
  logic [NUM_CH*PWM_W-1:0]    vu_level;
  logic [NUM_CH*PWM_W-1:0]    vu_peak;
  logic                       level_valid;

  modport master (
    output audio_clk_enable,
    output audio_enable,
    output audio_sample,
    input  vu_pwm,
    input  vu_level,
    input  vu_peak,
    input  level_valid
  );

  modport slave (
    input  audio_clk_enable,
    input  audio_enable,
    input  audio_sample,
    output vu_pwm,
    output vu_level,
    output vu_peak,
    output level_valid
  );
endinterface

// File: rtl/vu_meter_ballistics.sv
// N-channel VU meter driver: rectify, window-average, attack/decay ballistics, glitch-free PWM.
// Optional peak hold is built only when VU_PEAK_HOLD_EN is defined; otherwise vu_peak is tied to 0.
module vu_meter_ballistics #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned SAMPLE_W     = 8,
  parameter int unsigned AVG_LOG2     = 4,
  parameter int unsigned PWM_W        = 7,
  parameter int unsigned ATTACK_SHIFT = 0,
  parameter int unsigned DECAY_SHIFT  = 3,
  parameter int unsigned HOLD_WINDOWS = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  vu_meter_ballistics_if.slave bus
);

  localparam int unsigned MAG_W = SAMPLE_W - 1;
  localparam int unsigned ACC_W = MAG_W + AVG_LOG2;

  typedef logic [PWM_W-1:0] lvl_t;

  // Elaboration-time parameter sanity.
  if (PWM_W > SAMPLE_W - 1 || AVG_LOG2 == 0 || HOLD_WINDOWS == 0) begin : g_param_check
    $error("vu_meter_ballistics: illegal parameter set");
  end

  logic                sample_acc;
  logic                win_last;
  logic [AVG_LOG2-1:0] win_q, win_d;
  logic                upd_q, upd_d;
  logic [SAMPLE_W-1:0] smp     [NUM_CH];
  logic [SAMPLE_W-1:0] smp_neg [NUM_CH];
  logic [MAG_W-1:0]    mag     [NUM_CH];
  logic [ACC_W-1:0]    acc_sum [NUM_CH];
  logic [ACC_W-1:0]    acc_q   [NUM_CH];
  logic [ACC_W-1:0]    acc_d   [NUM_CH];
  lvl_t                mean_q  [NUM_CH];
  lvl_t                mean_d  [NUM_CH];
  lvl_t                level_q [NUM_CH];
  lvl_t                level_d [NUM_CH];
  lvl_t                duty_q  [NUM_CH];
  lvl_t                duty_d  [NUM_CH];
  lvl_t                cnt_q, cnt_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d;

  // Step never exceeds the distance to the mean, so the result stays inside [0, 2^PWM_W-1].
  function automatic lvl_t ballistic(input lvl_t lvl, input lvl_t mean);
    lvl_t diff;
    lvl_t step;
    diff = '0;
    step = '0;
    if (mean > lvl) begin
      diff = mean - lvl;
      step = diff >> ATTACK_SHIFT;
      if (step == '0) step = lvl_t'(1);
      return lvl + step;
    end else if (mean < lvl) begin
      diff = lvl - mean;
      step = diff >> DECAY_SHIFT;
      if (step == '0) step = lvl_t'(1);
      return lvl - step;
    end
    return lvl;
  endfunction

  // Rectifier; the most-negative code saturates to full scale.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      smp[c]     = bus.audio_sample[c*SAMPLE_W +: SAMPLE_W];
      smp_neg[c] = (~smp[c]) + SAMPLE_W'(1);
      if (!smp[c][SAMPLE_W-1]) begin
        mag[c] = smp[c][SAMPLE_W-2:0];
      end else if (smp[c][SAMPLE_W-2:0] == '0) begin
        mag[c] = '1;
      end else begin
        mag[c] = smp_neg[c][SAMPLE_W-2:0];
      end
    end
  end

  // Window accumulation and ballistics.
  always_comb begin
    sample_acc = bus.audio_clk_enable && bus.audio_enable;
    win_last   = (win_q == '1);
    win_d      = win_q;
    upd_d      = 1'b0;
    if (!bus.audio_enable) begin
      win_d = '0;
    end else if (sample_acc) begin
      win_d = win_q + AVG_LOG2'(1);
      upd_d = win_last;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      acc_sum[c] = acc_q[c] + ACC_W'(mag[c]);
      acc_d[c]   = acc_q[c];
      mean_d[c]  = mean_q[c];
      level_d[c] = level_q[c];
      if (!bus.audio_enable) begin
        acc_d[c]   = '0;
        mean_d[c]  = '0;
        level_d[c] = '0;
      end else begin
        if (sample_acc) begin
          if (win_last) begin
            // Final sample folded in here so the window holds exactly 2^AVG_LOG2 samples.
            acc_d[c]  = '0;
            mean_d[c] = acc_sum[c][ACC_W-1 -: PWM_W];
          end else begin
            acc_d[c] = acc_sum[c];
          end
        end
        if (upd_q) level_d[c] = ballistic(level_q[c], mean_q[c]);
      end
    end
  end

  // PWM: duty only changes as the counter wraps, so a period is never split.
  always_comb begin
    cnt_d = cnt_q + lvl_t'(1);
    pwm_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      duty_d[c] = duty_q[c];
      if (!bus.audio_enable) begin
        duty_d[c] = '0;
      end else if (cnt_q == '1) begin
        duty_d[c] = level_q[c];
      end
      pwm_d[c] = bus.audio_enable && (cnt_d < duty_d[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      upd_q <= 1'b0;
      cnt_q <= '0;
      pwm_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]   <= '0;
        mean_q[c]  <= '0;
        level_q[c] <= '0;
        duty_q[c]  <= '0;
      end
    end else begin
      win_q <= win_d;
      upd_q <= upd_d;
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      for (int c = 0; c < NUM_CH; c++) begin
        acc_q[c]   <= acc_d[c];
        mean_q[c]  <= mean_d[c];
        level_q[c] <= level_d[c];
        duty_q[c]  <= duty_d[c];
      end
    end
  end

  assign bus.level_valid = upd_q;
  assign bus.vu_pwm      = pwm_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_level_out
    assign bus.vu_level[c*PWM_W +: PWM_W] = level_q[c];
  end

`ifdef VU_PEAK_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_WINDOWS + 1);

  lvl_t              peak_q [NUM_CH];
  lvl_t              peak_d [NUM_CH];
  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [HOLD_W-1:0] hold_d [NUM_CH];

  // Compares against the level being written this cycle, not the stale one.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      peak_d[c] = peak_q[c];
      hold_d[c] = hold_q[c];
      if (!bus.audio_enable) begin
        peak_d[c] = '0;
        hold_d[c] = '0;
      end else if (upd_q) begin
        if (level_d[c] >= peak_q[c]) begin
          peak_d[c] = level_d[c];
          hold_d[c] = HOLD_W'(HOLD_WINDOWS);
        end else if (hold_q[c] != '0) begin
          hold_d[c] = hold_q[c] - HOLD_W'(1);
        end else begin
          peak_d[c] = level_d[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        peak_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        peak_q[c] <= peak_d[c];
        hold_q[c] <= hold_d[c];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_peak_out
    assign bus.vu_peak[c*PWM_W +: PWM_W] = peak_q[c];
  end
`else
  assign bus.vu_peak = '0;
`endif

endmodule

// File: tb/tb_vu_meter_ballistics.sv
// Directed bench for vu_meter_ballistics: windowing, ballistics, PWM duty, enable clear, reset.
// Peak-hold expectations follow VU_PEAK_HOLD_EN (HOLD_WINDOWS overridden to 4).
module tb_vu_meter_ballistics;
  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned PWM_W    = 7;
`ifdef VU_PEAK_HOLD_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vu_meter_ballistics_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PWM_W(PWM_W)) bus ();

  vu_meter_ballistics #(
    .NUM_CH      (NUM_CH),
    .SAMPLE_W    (SAMPLE_W),
    .AVG_LOG2    (4),
    .PWM_W       (PWM_W),
    .ATTACK_SHIFT(0),
    .DECAY_SHIFT (3),
    .HOLD_WINDOWS(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [31:0] lvl(input int c);
    return 32'(bus.vu_level[c*PWM_W +: PWM_W]);
  endfunction

  function automatic logic [31:0] pk(input int c);
    return 32'(bus.vu_peak[c*PWM_W +: PWM_W]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobe is seen by exactly one posedge, returns at the next negedge.
  task automatic strobe(input logic [7:0] s0, input logic [7:0] s1);
    bus.audio_sample     = {s1, s0};
    bus.audio_clk_enable = 1'b1;
    @(negedge clk);
    bus.audio_clk_enable = 1'b0;
  endtask

  task automatic window(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                        input int e0, input int e1);
    repeat (15) begin
      strobe(s0, s1);
      @(negedge clk);
    end
    check({tag, "_valid_early"}, 32'(bus.level_valid), 0);
    strobe(s0, s1);
    check({tag, "_valid"}, 32'(bus.level_valid), 1);
    @(negedge clk);
    check({tag, "_valid_end"}, 32'(bus.level_valid), 0);
    check({tag, "_lvl0"}, lvl(0), 32'(e0));
    check({tag, "_lvl1"}, lvl(1), 32'(e1));
  endtask

  // Counts PWM high cycles over one full period once the new duty is certainly latched.
  task automatic pwm_count(input string tag, input int e0, input int e1);
    int h0;
    int h1;
    h0 = 0;
    h1 = 0;
    repeat (130) @(negedge clk);
    repeat (128) begin
      @(negedge clk);
      h0 += int'(bus.vu_pwm[0]);
      h1 += int'(bus.vu_pwm[1]);
    end
    check({tag, "_pwm0"}, 32'(h0), 32'(e0));
    check({tag, "_pwm1"}, 32'(h1), 32'(e1));
  endtask

  initial begin
    int exp0 [5];
    int exp1 [5];
    int expk [5];
    exp0 = '{112, 98, 86, 76, 67};
    exp1 = '{14, 13, 12, 11, 10};
    expk = '{127, 127, 127, 127, 67};

    bus.audio_clk_enable = 1'b0;
    bus.audio_enable     = 1'b0;
    bus.audio_sample     = '0;
    repeat (3) @(negedge clk);
    check("rst_lvl", 32'(bus.vu_level), 0);
    check("rst_pwm", 32'(bus.vu_pwm), 0);
    check("rst_valid", 32'(bus.level_valid), 0);
    check("rst_peak", 32'(bus.vu_peak), 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.audio_enable = 1'b1;
    @(negedge clk);

    // Steady half-scale tone on both channels.
    window("t2", 8'h40, 8'h40, 64, 64);
    pwm_count("t2", 64, 64);

    // Clear, then saturated negative full-scale on ch0 and small tone on ch1.
    bus.audio_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_lvl", 32'(bus.vu_level), 0);
    check("clr_pwm", 32'(bus.vu_pwm), 0);
    bus.audio_enable = 1'b1;
    @(negedge clk);
    window("t3", 8'h80, 8'h10, 127, 16);
    check("t3_peak0", pk(0), PEAK_ON ? 32'd127 : 32'd0);
    pwm_count("t3", 127, 16);

    // Decay toward silence; peak holds for four updates then tracks.
    for (int i = 0; i < 5; i++) begin
      window($sformatf("t4_w%0d", i), 8'h00, 8'h00, exp0[i], exp1[i]);
      check($sformatf("t4_peak_w%0d", i), pk(0), PEAK_ON ? 32'(expk[i]) : 32'd0);
    end
    repeat (35 * 32) begin
      strobe(8'h00, 8'h00);
      @(negedge clk);
    end
    check("t4_floor0", lvl(0), 0);
    check("t4_floor1", lvl(1), 0);

    // Mid-window disable discards the partial window.
    window("t5a", 8'h40, 8'h40, 64, 64);
    repeat (9) begin
      strobe(8'h40, 8'h40);
      @(negedge clk);
    end
    bus.audio_enable = 1'b0;
    @(negedge clk);
    check("t5_off_lvl", 32'(bus.vu_level), 0);
    check("t5_off_pwm", 32'(bus.vu_pwm), 0);
    check("t5_off_peak", 32'(bus.vu_peak), 0);
    repeat (20) begin
      strobe(8'h7f, 8'h7f);
      check("t5_ignored_valid", 32'(bus.level_valid), 0);
      @(negedge clk);
    end
    check("t5_ignored_lvl", 32'(bus.vu_level), 0);
    bus.audio_enable = 1'b1;
    @(negedge clk);
    window("t5b", 8'h20, 8'h20, 32, 32);

    // Asynchronous reset between clock edges with meters active.
    window("t1", 8'h80, 8'h80, 127, 127);
    repeat (200) @(negedge clk);
    for (int i = 0; i < 4 && bus.vu_pwm != 2'b11; i++) @(negedge clk);
    check("t1_pre_pwm", 32'(bus.vu_pwm), 3);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_lvl", 32'(bus.vu_level), 0);
    check("t1_rst_pwm", 32'(bus.vu_pwm), 0);
    check("t1_rst_valid", 32'(bus.level_valid), 0);
    check("t1_rst_peak", 32'(bus.vu_peak), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
